// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: write-port scheduler in front of the 16x32 register file.
// Two writeback sources each own a one-entry buffer. Buffered writes are issued to
// the file's two write ports. When both buffers target the same register, src1 is
// written first and src0 on the next cycle, so src0's value is the one that stays.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   s0_valid/ready/addr/data   src0 (ALU/result writeback) request, buffered
//   s1_valid/ready/addr/data   src1 (base-register update) request, buffered
//   wr1_en/addr/data      file write port 1, carries src0
//   wr2_en/addr/data      file write port 2, carries src1
//   busy_mask             bit r set while a buffered write to register r is pending
//   collide_cnt           saturating count of same-address collisions
//   idle                  both buffers empty
//
// CNT_W sets the internal collision counter width (zero-extended onto collide_cnt);
// leave it at 16 for the full-range counter.
module regfile_wr_sched #(
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned NREG  = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic [AW-1:0]   s0_addr,
  input  logic [DW-1:0]   s0_data,
  input  logic            s1_valid,
  output logic            s1_ready,
  input  logic [AW-1:0]   s1_addr,
  input  logic [DW-1:0]   s1_data,
  output logic            wr1_en,
  output logic [AW-1:0]   wr1_addr,
  output logic [DW-1:0]   wr1_data,
  output logic            wr2_en,
  output logic [AW-1:0]   wr2_addr,
  output logic [DW-1:0]   wr2_data,
  output logic [NREG-1:0] busy_mask,
  output logic [15:0]     collide_cnt,
  output logic            idle
);

  localparam logic [0:0] StNormal = 1'b0;
  localparam logic [0:0] StFavor0 = 1'b1;

  localparam logic [CNT_W-1:0] CntOne = 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [0:0]       state_q, state_d;
  logic             bv0_q, bv0_d, bv1_q, bv1_d;
  logic [AW-1:0]    ba0_q, ba0_d, ba1_q, ba1_d;
  logic [DW-1:0]    bd0_q, bd0_d, bd1_q, bd1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic issue0, issue1, collide;

  // Issue decision depends only on buffer state and FSM, never on incoming valids.
  always_comb begin
    state_d = state_q;
    issue0  = 1'b0;
    issue1  = 1'b0;
    collide = 1'b0;
    case (state_q)
      StNormal: begin
        if (bv0_q && bv1_q) begin
          if (ba0_q != ba1_q) begin
            issue0 = 1'b1;
            issue1 = 1'b1;
          end else begin
            // src1 goes first so src0 overwrites it one cycle later.
            issue1  = 1'b1;
            collide = 1'b1;
            state_d = StFavor0;
          end
        end else begin
          issue0 = bv0_q;
          issue1 = bv1_q;
        end
      end
      StFavor0: begin
        state_d = StNormal;
        if (bv0_q) begin
          issue0 = 1'b1;
          issue1 = bv1_q && (ba1_q != ba0_q);
        end else begin
          issue1 = bv1_q;
        end
      end
      default: state_d = StNormal;
    endcase
  end

  // A draining buffer may reload on the same edge; src1 is held while src0 catches up.
  always_comb begin
    s0_ready = !bv0_q || issue0;
    if (state_q == StFavor0) begin
      s1_ready = !bv1_q;
    end else begin
      s1_ready = !bv1_q || issue1;
    end
  end

  always_comb begin
    bv0_d = bv0_q && !issue0;
    ba0_d = ba0_q;
    bd0_d = bd0_q;
    if (s0_valid && s0_ready) begin
      bv0_d = 1'b1;
      ba0_d = s0_addr;
      bd0_d = s0_data;
    end
    bv1_d = bv1_q && !issue1;
    ba1_d = ba1_q;
    bd1_d = bd1_q;
    if (s1_valid && s1_ready) begin
      bv1_d = 1'b1;
      ba1_d = s1_addr;
      bd1_d = s1_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (collide && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StNormal;
      bv0_q   <= 1'b0;
      ba0_q   <= '0;
      bd0_q   <= '0;
      bv1_q   <= 1'b0;
      ba1_q   <= '0;
      bd1_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bv0_q   <= bv0_d;
      ba0_q   <= ba0_d;
      bd0_q   <= bd0_d;
      bv1_q   <= bv1_d;
      ba1_q   <= ba1_d;
      bd1_q   <= bd1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr1_en   = issue0;
  assign wr1_addr = ba0_q;
  assign wr1_data = bd0_q;
  assign wr2_en   = issue1;
  assign wr2_addr = ba1_q;
  assign wr2_data = bd1_q;
  assign idle     = !bv0_q && !bv1_q;

  always_comb begin
    busy_mask = '0;
    if (bv0_q) busy_mask[ba0_q] = 1'b1;
    if (bv1_q) busy_mask[ba1_q] = 1'b1;
  end

  always_comb begin
    collide_cnt            = '0;
    collide_cnt[CNT_W-1:0] = cnt_q;
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched. Inputs change 1ns after a rising edge,
// outputs are sampled on the falling edge. A second instance with a 4-bit
// counter shares all inputs and shows saturation without 65536 collisions.
module tb_regfile_wr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_valid, s1_valid;
  logic [3:0]  s0_addr, s1_addr;
  logic [31:0] s0_data, s1_data;
  logic        s0_ready, s1_ready;
  logic        wr1_en, wr2_en;
  logic [3:0]  wr1_addr, wr2_addr;
  logic [31:0] wr1_data, wr2_data;
  logic [15:0] busy_mask, collide_cnt;
  logic        idle;

  logic        n_s0_ready, n_s1_ready, n_wr1_en, n_wr2_en, n_idle;
  logic [3:0]  n_wr1_addr, n_wr2_addr;
  logic [31:0] n_wr1_data, n_wr2_data;
  logic [15:0] n_busy_mask, n_collide_cnt;

  logic [31:0] rf [16];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regfile_wr_sched dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
    .busy_mask(busy_mask), .collide_cnt(collide_cnt), .idle(idle)
  );

  regfile_wr_sched #(.CNT_W(4)) dut_nar (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(n_s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(n_s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .wr1_en(n_wr1_en), .wr1_addr(n_wr1_addr), .wr1_data(n_wr1_data),
    .wr2_en(n_wr2_en), .wr2_addr(n_wr2_addr), .wr2_data(n_wr2_data),
    .busy_mask(n_busy_mask), .collide_cnt(n_collide_cnt), .idle(n_idle)
  );

  // Register file model fed by the write ports.
  always @(posedge clk) begin
    if (wr1_en) rf[wr1_addr] <= wr1_data;
    if (wr2_en) rf[wr2_addr] <= wr2_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [3:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [3:0] a1, input logic [31:0] d1);
    s0_valid = v0; s0_addr = a0; s0_data = d0;
    s1_valid = v1; s1_addr = a1; s1_data = d1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    check("rst_wr1_en", wr1_en, 0);
    check("rst_wr2_en", wr2_en, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_idle", idle, 1);
    check("rst_s0_ready", s0_ready, 1);
    check("rst_s1_ready", s1_ready, 1);
    check("rst_cnt", collide_cnt, 0);
    check("rst_wr1_addr", wr1_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Distinct addresses: both ports strobe one cycle after acceptance.
    drive(1, 4'd3, 32'h11, 1, 4'd7, 32'h22);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("dist_wr1_en", wr1_en, 1);
    check("dist_wr1_addr", wr1_addr, 3);
    check("dist_wr1_data", wr1_data, 32'h11);
    check("dist_wr2_en", wr2_en, 1);
    check("dist_wr2_addr", wr2_addr, 7);
    check("dist_wr2_data", wr2_data, 32'h22);
    check("dist_busy", busy_mask, 16'h0088);
    check("dist_idle", idle, 0);
    next_cycle();
    @(negedge clk);
    check("dist_done_idle", idle, 1);
    check("dist_done_busy", busy_mask, 0);
    check("dist_r3", rf[3], 32'h11);
    check("dist_r7", rf[7], 32'h22);

    // Same-address collision: src1 first, then src0.
    next_cycle();
    drive(1, 4'd5, 32'hAAAA, 1, 4'd5, 32'hBBBB);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("col_c1_wr2_en", wr2_en, 1);
    check("col_c1_wr1_en", wr1_en, 0);
    check("col_c1_wr2_data", wr2_data, 32'hBBBB);
    check("col_c1_busy", busy_mask, 16'h0020);
    check("col_c1_s0_ready", s0_ready, 0);
    next_cycle();
    @(negedge clk);
    check("col_c2_wr1_en", wr1_en, 1);
    check("col_c2_wr2_en", wr2_en, 0);
    check("col_c2_wr1_addr", wr1_addr, 5);
    check("col_c2_wr1_data", wr1_data, 32'hAAAA);
    check("col_c2_cnt", collide_cnt, 1);
    check("col_c2_r5", rf[5], 32'hBBBB);
    next_cycle();
    @(negedge clk);
    check("col_r5_final", rf[5], 32'hAAAA);
    check("col_idle", idle, 1);

    // src1 streams to r9 while src0 targets r9.
    next_cycle();
    drive(0, 0, 0, 1, 4'd9, 32'h101);
    next_cycle();
    drive(1, 4'd9, 32'hC, 1, 4'd9, 32'h102);
    @(negedge clk);
    check("str_a_wr2_data", wr2_data, 32'h101);
    check("str_a_s1_ready", s1_ready, 1);
    check("str_a_s0_ready", s0_ready, 1);
    next_cycle();
    drive(0, 0, 0, 1, 4'd9, 32'h103);
    @(negedge clk);
    check("str_col_wr2_en", wr2_en, 1);
    check("str_col_wr2_data", wr2_data, 32'h102);
    check("str_col_wr1_en", wr1_en, 0);
    check("str_col_busy", busy_mask, 16'h0200);
    next_cycle();
    drive(0, 0, 0, 1, 4'd9, 32'h104);
    @(negedge clk);
    check("str_fav_wr1_en", wr1_en, 1);
    check("str_fav_wr1_data", wr1_data, 32'hC);
    check("str_fav_wr2_en", wr2_en, 0);
    check("str_fav_s1_ready", s1_ready, 0);
    check("str_fav_wr2_data", wr2_data, 32'h103);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("str_r9_c", rf[9], 32'hC);
    check("str_held_wr2_en", wr2_en, 1);
    check("str_held_wr2_data", wr2_data, 32'h103);
    check("str_cnt", collide_cnt, 2);
    next_cycle();
    @(negedge clk);
    check("str_r9_final", rf[9], 32'h103);
    check("str_idle", idle, 1);

    // Back-to-back src0 writes at one per cycle.
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 4'(i), 32'h50 + 32'(i), 0, 0, 0);
      @(negedge clk);
      check("b2b_s0_ready", s0_ready, 1);
      if (i > 1) begin
        check("b2b_wr1_en", wr1_en, 1);
        check("b2b_wr1_addr", wr1_addr, 32'(i - 1));
      end
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("b2b_last_addr", wr1_addr, 4);
    next_cycle();
    @(negedge clk);
    for (int i = 1; i <= 4; i++) check("b2b_rf", rf[i], 32'h50 + 32'(i));

    // Repeated collisions; the 4-bit instance must stick at its maximum.
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      drive(1, 4'd6, 32'(i), 1, 4'd6, 32'(i + 100));
      next_cycle();
      drive(0, 0, 0, 0, 0, 0);
      next_cycle();
      next_cycle();
      if (i == 12) check("sat_reach", n_collide_cnt, 16'h000F);
    end
    @(negedge clk);
    check("sat_hold", n_collide_cnt, 16'h000F);
    check("sat_main_cnt", collide_cnt, 22);
    check("sat_r6", rf[6], 32'd19);

    // Asynchronous reset in the middle of a collision.
    next_cycle();
    drive(1, 4'd2, 32'h77, 1, 4'd2, 32'h88);
    next_cycle();
    drive(0, 0, 0, 1, 4'd4, 32'h99);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wr1_en", wr1_en, 0);
    check("arst_wr2_en", wr2_en, 0);
    check("arst_busy", busy_mask, 0);
    check("arst_cnt", collide_cnt, 0);
    check("arst_idle", idle, 1);
    check("arst_s1_ready", s1_ready, 1);
    check("arst_wr2_data", wr2_data, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    drive(1, 4'd2, 32'h5, 1, 4'd2, 32'h6);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_wr2_en", wr2_en, 1);
    check("post_rst_wr1_en", wr1_en, 0);
    check("post_rst_wr2_data", wr2_data, 32'h6);
    next_cycle();
    @(negedge clk);
    check("post_rst_cnt", collide_cnt, 1);
    check("post_rst_wr1_data", wr1_data, 32'h5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
